monopix_hit_decoder: RTL and testbench

MONOPIX_HIT_DECODER -- requirements
Module: monopix_hit_decoder

---
 rtl/monopix_hit_decoder.sv | 110 +++++++++++
 tb/tb_monopix_hit_decoder.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/monopix_hit_decoder.sv
// Monopix hit decoder: Gray-decodes deserialised hit words, computes time-over-threshold,
// and buffers the results in a first-word-fall-through FIFO with lost-hit accounting.
module monopix_hit_decoder #(
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 16
) (
  input  logic                        clk_out,
  input  logic                        reset,
  input  logic [26:0]                 data_in,
  input  logic                        data_in_strobe,
  output logic [31:0]                 out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic [CNT_W-1:0]            lost_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  function automatic logic [5:0] gray2bin(input logic [5:0] g);
    logic [5:0] b;
    // NOTE: blocking '=' is correct here -- each bit depends on the one computed just before it.
    b[5] = g[5];
    for (int i = 4; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  // Stage 1: decode register
  logic       dec_valid;
  logic [5:0] dec_col;
  logic [8:0] dec_row;
  logic [5:0] dec_le;
  logic [5:0] dec_te;

  always_ff @(posedge clk_out) begin
    if (reset) begin
      dec_valid <= 1'b0;
    end else begin
      dec_valid <= data_in_strobe;
      if (data_in_strobe) begin
        dec_col <= data_in[26:21];
        dec_te  <= gray2bin(data_in[20:15]);
        dec_le  <= gray2bin(data_in[14:9]);
        dec_row <= data_in[8:0];
      end
    end
  end

  // Stage 2: FIFO write, with drop accounting when full
  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          lost_flag;
  logic [5:0]    tot;
  logic [31:0]   wr_word;
  logic          full;
  logic          pop;
  logic          wr_accept;
  logic          wr_drop;
  logic [CW-1:0] count_next;

  // Six-bit subtraction gives the modulo-64 wrap directly.
  assign tot       = dec_te - dec_le;
  assign wr_word   = {lost_flag, 4'b0000, dec_col, dec_row, dec_le, tot};
  assign full      = (fifo_count == DEPTH_C);
  assign out_valid = (fifo_count != '0);
  assign pop       = out_valid & out_ready;
  // A pop frees the head slot in the same edge, so a full FIFO can still take the write.
  assign wr_accept = dec_valid & (~full | pop);
  assign wr_drop   = dec_valid & full & ~pop;
  assign out_data  = out_valid ? mem[rd_ptr] : 32'd0;

  always_comb begin
    // NOTE: default assignment first so no path through the case leaves count_next unassigned (no latch).
    count_next = fifo_count;
    unique case ({wr_accept, pop})
      2'b10:   count_next = fifo_count + 1'b1;
      2'b01:   count_next = fifo_count - 1'b1;
      default: count_next = fifo_count;
    endcase
  end

  // NOTE: storage RAM has no reset; validity is tracked entirely by the pointers and count.
  always_ff @(posedge clk_out) begin
    if (wr_accept) mem[wr_ptr] <= wr_word;
  end

  always_ff @(posedge clk_out) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      lost_cnt   <= '0;
      lost_flag  <= 1'b0;
    end else begin
      fifo_count <= count_next;
      if (wr_accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)       rd_ptr <= rd_ptr + 1'b1;
      if (wr_drop) begin
        lost_flag <= 1'b1;
        if (lost_cnt != '1) lost_cnt <= lost_cnt + 1'b1;
      end else if (wr_accept) begin
        lost_flag <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_monopix_hit_decoder.sv
// Directed bench for monopix_hit_decoder: a vector table for the decode path plus
// hand-written sequences for overflow, full-with-pop, back-to-back and reset cases.
module tb_monopix_hit_decoder;

  logic        clk_out = 1'b0;
  logic        reset;
  logic [26:0] data_in;
  logic        data_in_strobe;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  fifo_count;
  logic [15:0] lost_cnt;

  int total = 0;
  int bad   = 0;

  monopix_hit_decoder #(.FIFO_DEPTH(16), .CNT_W(16)) dut (
    .clk_out        (clk_out),
    .reset          (reset),
    .data_in        (data_in),
    .data_in_strobe (data_in_strobe),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .fifo_count     (fifo_count),
    .lost_cnt       (lost_cnt)
  );

  always #5 clk_out = ~clk_out;

  typedef struct {
    logic [5:0]  col;
    logic [8:0]  row;
    logic [5:0]  le_g;
    logic [5:0]  te_g;
    logic [31:0] exp_word;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_out);
    #1;
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    data_in_strobe = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic send(input logic [5:0] col, input logic [8:0] row,
                      input logic [5:0] le_g, input logic [5:0] te_g);
    data_in        = {col, te_g, le_g, row};
    data_in_strobe = 1'b1;
    tick();
    data_in_strobe = 1'b0;
  endtask

  function automatic logic [31:0] plain_word(input logic lost, input logic [5:0] col,
                                             input logic [8:0] row);
    return {lost, 4'b0000, col, row, 12'd0};
  endfunction

  initial begin
    reset          = 1'b1;
    data_in        = '0;
    data_in_strobe = 1'b0;
    out_ready      = 1'b1;

    // Gray decodes worked by hand: 000011->2, 000110->4, 100001->62, 000001->1,
    // 101010->51, 100000->63, 000000->0.
    vecs[0] = '{col: 6'd5,  row: 9'd100, le_g: 6'b000011, te_g: 6'b000110,
                exp_word: {1'b0, 4'b0000, 6'd5,  9'd100, 6'd2,  6'd2}};
    vecs[1] = '{col: 6'd63, row: 9'd511, le_g: 6'b100001, te_g: 6'b000001,
                exp_word: {1'b0, 4'b0000, 6'd63, 9'd511, 6'd62, 6'd3}};
    vecs[2] = '{col: 6'd0,  row: 9'd0,   le_g: 6'b101010, te_g: 6'b101010,
                exp_word: {1'b0, 4'b0000, 6'd0,  9'd0,   6'd51, 6'd0}};
    vecs[3] = '{col: 6'd33, row: 9'd256, le_g: 6'b000000, te_g: 6'b100000,
                exp_word: {1'b0, 4'b0000, 6'd33, 9'd256, 6'd0,  6'd63}};

    tick();
    tick();
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_data", out_data, 32'd0);
    check("reset_fifo_count", 32'(fifo_count), 32'd0);
    check("reset_lost_cnt", 32'(lost_cnt), 32'd0);
    reset = 1'b0;

    // Decode table: out_valid must still be low one cycle after strobe, high after two.
    for (int v = 0; v < 4; v++) begin
      send(vecs[v].col, vecs[v].row, vecs[v].le_g, vecs[v].te_g);
      check($sformatf("vec%0d_latency1", v), 32'(out_valid), 32'd0);
      tick();
      check($sformatf("vec%0d_valid", v), 32'(out_valid), 32'd1);
      check($sformatf("vec%0d_data", v), out_data, vecs[v].exp_word);
      tick();
      check($sformatf("vec%0d_popped", v), 32'(out_valid), 32'd0);
    end

    // Overflow: 17 strobes into a stalled FIFO, row 16 dropped.
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 17; i++) send(6'd0, 9'(i), 6'd0, 6'd0);
    tick();
    tick();
    check("ovf_fifo_count", 32'(fifo_count), 32'd16);
    check("ovf_lost_cnt", 32'(lost_cnt), 32'd1);
    tick();
    check("ovf_head_stable", out_data, plain_word(1'b0, 6'd0, 9'd0));
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("ovf_drain%0d", i), out_data, plain_word(1'b0, 6'd0, 9'(i)));
      tick();
    end
    check("ovf_empty", 32'(out_valid), 32'd0);
    send(6'd0, 9'd20, 6'd0, 6'd0);
    tick();
    check("ovf_lost_bit_set", out_data, plain_word(1'b1, 6'd0, 9'd20));
    tick();
    send(6'd0, 9'd21, 6'd0, 6'd0);
    tick();
    check("ovf_lost_bit_clear", out_data, plain_word(1'b0, 6'd0, 9'd21));
    tick();

    // Full FIFO with a pop in the same edge as the pending write.
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) send(6'd1, 9'(i), 6'd0, 6'd0);
    tick();
    check("fullpop_pre_count", 32'(fifo_count), 32'd16);
    data_in        = {6'd1, 6'd0, 6'd0, 9'd30};
    data_in_strobe = 1'b1;
    tick();
    data_in_strobe = 1'b0;
    out_ready      = 1'b1;
    tick();
    out_ready = 1'b0;
    check("fullpop_count", 32'(fifo_count), 32'd16);
    check("fullpop_lost_cnt", 32'(lost_cnt), 32'd0);
    check("fullpop_head", out_data, plain_word(1'b0, 6'd1, 9'd1));
    out_ready = 1'b1;
    for (int i = 1; i < 16; i++) begin
      check($sformatf("fullpop_drain%0d", i), out_data, plain_word(1'b0, 6'd1, 9'(i)));
      tick();
    end
    check("fullpop_tail", out_data, plain_word(1'b0, 6'd1, 9'd30));
    tick();
    check("fullpop_empty", 32'(out_valid), 32'd0);

    // Back-to-back strobes with a free-running consumer.
    begin
      int got;
      do_reset();
      out_ready = 1'b1;
      got = 0;
      for (int cyc = 0; cyc < 50; cyc++) begin
        if (out_valid) begin
          check($sformatf("b2b_word%0d", got), out_data,
                {1'b0, 4'b0000, 6'(got % 64), 9'(got + 100), 6'd2, 6'd2});
          got++;
        end
        if (cyc < 40) begin
          data_in        = {6'(cyc % 64), 6'b000110, 6'b000011, 9'(cyc + 100)};
          data_in_strobe = 1'b1;
        end else begin
          data_in_strobe = 1'b0;
        end
        tick();
      end
      check("b2b_count", 32'(got), 32'd40);
      check("b2b_lost_cnt", 32'(lost_cnt), 32'd0);
    end

    // Reset mid-operation: five stored words plus one in the decode stage.
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) send(6'd2, 9'(i), 6'd0, 6'd0);
    check("rst_mid_pre_count", 32'(fifo_count), 32'd5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_mid_valid", 32'(out_valid), 32'd0);
    check("rst_mid_count", 32'(fifo_count), 32'd0);
    check("rst_mid_data", out_data, 32'd0);
    check("rst_mid_lost", 32'(lost_cnt), 32'd0);
    out_ready = 1'b1;
    tick();
    tick();
    check("rst_mid_no_stale", 32'(out_valid), 32'd0);

    // Strobe coincident with reset is discarded; the next one is processed.
    reset          = 1'b1;
    data_in        = {6'd3, 6'd0, 6'd0, 9'd7};
    data_in_strobe = 1'b1;
    tick();
    reset          = 1'b0;
    data_in_strobe = 1'b0;
    tick();
    tick();
    check("rst_strobe_discarded", 32'(out_valid), 32'd0);
    send(6'd3, 9'd8, 6'd0, 6'd0);
    tick();
    check("rst_first_strobe", out_data, plain_word(1'b0, 6'd3, 9'd8));
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
